score_bcd_counter: RTL

Tetris score and line accumulator feeding the serial display driver on the SWORD board. It receives line-clear and soft-drop events from the game logic and keeps a 6-digit packed-BCD score, a 3-digit BCD line count and the current level. The 24-bit `score` output drives the display driver's parallel input directly. `score` changes only once per completed event, so the display reloads exactly once per event.

---
 rtl/score_bcd_counter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/score_bcd_counter.sv
// Packed-BCD score (6 digits), line count (3 digits) and level tracker for the display driver.
// Latency: clear 4*level+1 cycles, drop 7 cycles, shorter on saturation; score updates once on DONE.
// Backpressure: busy is high while an event runs; events arriving while busy are dropped.
module score_bcd_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        restart,
   input  logic        add_valid,
   input  logic [2:0]  add_lines,
   input  logic        drop_pulse,
   output logic [23:0] score,
   output logic [11:0] lines,
   output logic [3:0]  level,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [23:0] score_q, score_d;
   logic [23:0] work_q, work_d;
   logic [11:0] lines_q, lines_d;
   logic [2:0]  digit_q, digit_d;
   logic [2:0]  start_q, start_d;
   logic [3:0]  addend_q, addend_d;
   logic [3:0]  pass_q, pass_d;
   logic        carry_q, carry_d;

   logic [2:0]  eff_lines;
   logic [3:0]  base_pts;
   logic [11:0] lines_sum;
   logic [4:0]  lvl_raw;
   logic [3:0]  cur_digit;
   logic [4:0]  dsum;
   logic [4:0]  dval;
   logic        dcarry;

   // Clamp the line count and map it to the base points added at the hundreds digit.
   always_comb begin
      eff_lines = (add_lines > 3'd4) ? 3'd4 : add_lines;
      case (eff_lines)
         3'd1:    base_pts = 4'd1;
         3'd2:    base_pts = 4'd3;
         3'd3:    base_pts = 4'd5;
         3'd4:    base_pts = 4'd8;
         default: base_pts = 4'd0;
      endcase
   end

   // BCD add of the cleared lines into the line count, pinned at 999 on overflow.
   always_comb begin
      logic [4:0] ls0, ls1, ls2;
      logic       lc0, lc1, lc2;
      ls0 = {1'b0, lines_q[3:0]} + {2'b00, eff_lines};
      lc0 = (ls0 > 5'd9);
      if (lc0) ls0 = ls0 - 5'd10;
      ls1 = {1'b0, lines_q[7:4]} + {4'd0, lc0};
      lc1 = (ls1 > 5'd9);
      if (lc1) ls1 = ls1 - 5'd10;
      ls2 = {1'b0, lines_q[11:8]} + {4'd0, lc1};
      lc2 = (ls2 > 5'd9);
      if (lc2) ls2 = ls2 - 5'd10;
      lines_sum = lc2 ? 12'h999 : {ls2[3:0], ls1[3:0], ls0[3:0]};
   end

   // Level follows the line count: tens digit plus one, 9 once hundreds is nonzero.
   always_comb begin
      lvl_raw = {1'b0, lines_q[7:4]} + 5'd1;
      if ((lines_q[11:8] != 4'd0) || (lvl_raw > 5'd9)) level = 4'd9;
      else                                             level = lvl_raw[3:0];
   end

   // One BCD digit of the work register: addend only at the start digit, carry everywhere.
   always_comb begin
      cur_digit = work_q[{digit_q, 2'b00} +: 4];
      dsum      = {1'b0, cur_digit} + {4'd0, carry_q}
                + ((digit_q == start_q) ? {1'b0, addend_q} : 5'd0);
      dcarry    = (dsum > 5'd9);
      dval      = dcarry ? (dsum - 5'd10) : dsum;
   end

   // Next-state logic: accept in IDLE, ripple digits in ADD, publish the result in DONE.
   always_comb begin
      state_d  = state_q;
      score_d  = score_q;
      work_d   = work_q;
      lines_d  = lines_q;
      digit_d  = digit_q;
      start_d  = start_q;
      addend_d = addend_q;
      pass_d   = pass_q;
      carry_d  = carry_q;
      case (state_q)
         S_IDLE: begin
            if (add_valid && (eff_lines != 3'd0)) begin
               work_d   = score_q;
               start_d  = 3'd2;
               digit_d  = 3'd2;
               addend_d = base_pts;
               pass_d   = level;
               carry_d  = 1'b0;
               lines_d  = lines_sum;
               state_d  = S_ADD;
            end else if (drop_pulse) begin
               work_d   = score_q;
               start_d  = 3'd0;
               digit_d  = 3'd0;
               addend_d = 4'd1;
               pass_d   = 4'd1;
               carry_d  = 1'b0;
               state_d  = S_ADD;
            end
         end
         S_ADD: begin
            work_d[{digit_q, 2'b00} +: 4] = dval[3:0];
            if (digit_q == 3'd5) begin
               if (dcarry) begin
                  // Overflow of the top digit: clamp and skip any remaining passes.
                  work_d  = 24'h999999;
                  state_d = S_DONE;
               end else begin
                  pass_d  = pass_q - 4'd1;
                  carry_d = 1'b0;
                  digit_d = start_q;
                  if (pass_q == 4'd1) state_d = S_DONE;
               end
            end else begin
               digit_d = digit_q + 3'd1;
               carry_d = dcarry;
            end
         end
         S_DONE: begin
            score_d = work_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset and restart abort any job in progress.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         state_q  <= S_IDLE;
         score_q  <= 24'h000000;
         work_q   <= 24'h000000;
         lines_q  <= 12'h000;
         digit_q  <= 3'd0;
         start_q  <= 3'd0;
         addend_q <= 4'd0;
         pass_q   <= 4'd0;
         carry_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         score_q  <= score_d;
         work_q   <= work_d;
         lines_q  <= lines_d;
         digit_q  <= digit_d;
         start_q  <= start_d;
         addend_q <= addend_d;
         pass_q   <= pass_d;
         carry_q  <= carry_d;
      end
   end

   assign score = score_q;
   assign lines = lines_q;
   assign busy  = (state_q != S_IDLE);

endmodule
